// File: rtl/ahb_slv_pkg.sv
// Shared definitions for the AHB memory slave: transfer size codes, FSM states
// and the little-endian byte-strobe helper.
package ahb_slv_pkg;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Bits below the access size are ignored; alignment is policed by the caller.
    function automatic logic [3:0] byte_strobe(input logic [2:0] size, input logic [1:0] a);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            HSIZE_BYTE: be = 4'b0001 << a;
            HSIZE_HALF: be = a[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: be = 4'b1111;
            default:    be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/ahb_slv_mem_array.sv
// DEPTH x 32 storage with per-byte write enables and a registered read port.
// Contents are never reset; only the read register clears on hreset.
module ahb_slv_mem_array #(
    parameter int unsigned DEPTH = 256,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          hclk,
    input  logic          hreset,
    input  logic [AW-1:0] addr,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [31:0]   wdata,
    input  logic          re,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge hclk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/ahb_slave_mem.sv
// Word-addressed AHB memory slave with configurable wait states and error responses.
// Define AHB_SLV_MEM_ALIGN_CHK_EN to reject misaligned halfword/word accesses.
module ahb_slave_mem
    import ahb_slv_pkg::*;
#(
    parameter int unsigned DEPTH       = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic        req_valid,
    input  logic [31:0] addr_out,
    input  logic [31:0] dout,
    input  logic        hwrite_out,
    input  logic [2:0]  hsize_out,
    output logic [31:0] din,
    output logic        ready,
    output logic        err
);

    localparam int          AW   = $clog2(DEPTH);
    localparam logic [31:0] SPAN = 32'(DEPTH * 4);
    localparam logic [3:0]  WS   = 4'(WAIT_STATES);

    state_t      state, state_nxt;
    logic [3:0]  wait_cnt;
    logic        accept, fire;

    logic [31:0] cap_addr, cap_wdata;
    logic        cap_write;
    logic [2:0]  cap_size;

    logic [31:0] x_addr, x_wdata, x_offset;
    logic        x_write, x_err, align_bad;
    logic [2:0]  x_size;
    logic [3:0]  x_be;

    logic        mem_we, mem_re;
    logic [31:0] rdata;
    logic        ready_q, err_q, zero_q;

    // The access happens on the edge entering RESP; with no wait states that is the accept edge itself.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        fire      = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept    = 1'b1;
                    state_nxt = (WS == 4'd0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt == 4'd1) begin
                    fire      = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (req_valid) begin
                    accept    = 1'b1;
                    state_nxt = (WS == 4'd0) ? RESP : WAIT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (accept && WS == 4'd0) begin
            fire = 1'b1;
        end
    end

    always_comb begin
        x_addr   = (state == WAIT) ? cap_addr  : addr_out;
        x_wdata  = (state == WAIT) ? cap_wdata : dout;
        x_write  = (state == WAIT) ? cap_write : hwrite_out;
        x_size   = (state == WAIT) ? cap_size  : hsize_out;
        x_offset = x_addr - BASE_ADDR;
        x_be     = byte_strobe(x_size, x_addr[1:0]);
`ifdef AHB_SLV_MEM_ALIGN_CHK_EN
        align_bad = ((x_size == HSIZE_HALF) && x_addr[0]) ||
                    ((x_size == HSIZE_WORD) && (x_addr[1:0] != 2'b00));
`else
        align_bad = 1'b0;
`endif
        x_err    = (x_offset >= SPAN) || (x_size > HSIZE_WORD) || align_bad;
        mem_we   = fire && x_write && !x_err && !hreset;
        mem_re   = fire && !x_write && !x_err && !hreset;
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            ready_q <= fire;
            err_q   <= fire && x_err;
            if (accept) begin
                wait_cnt <= WS;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (fire && x_err) begin
                zero_q <= 1'b1;
            end else if (mem_re) begin
                zero_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (accept) begin
            cap_addr  <= addr_out;
            cap_wdata <= dout;
            cap_write <= hwrite_out;
            cap_size  <= hsize_out;
        end
    end

    ahb_slv_mem_array #(.DEPTH(DEPTH)) u_array (
        .hclk   (hclk),
        .hreset (hreset),
        .addr   (x_offset[AW+1:2]),
        .we     (mem_we),
        .be     (x_be),
        .wdata  (x_wdata),
        .re     (mem_re),
        .rdata  (rdata)
    );

    // An error response forces din to zero until the next good read refreshes it.
    assign din   = zero_q ? 32'h0 : rdata;
    assign ready = ready_q;
    assign err   = err_q;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Scoreboard bench for ahb_slave_mem: one zero-wait instance at base 0 and one
// three-wait instance at base 0x1000, sharing stimulus through a selector.
module tb_ahb_slave_mem;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        write;
        logic [2:0]  size;
    } req_t;

    typedef struct {
        logic        err;
        logic        chk;
        logic [31:0] data;
    } exp_t;

    logic        hclk = 1'b0;
    logic        hreset;
    logic        req_valid;
    logic [31:0] addr_out, dout;
    logic        hwrite_out;
    logic [2:0]  hsize_out;
    logic [31:0] din0, din3, din_m;
    logic        ready0, ready3, ready_m, err0, err3, err_m;
    logic        rv0, rv3;

    int          sel = 0;
    int          errors = 0;
    int          checks = 0;
    req_t        req_q[$];
    exp_t        exp_q[$];
    logic [31:0] mdl [2][256];
    logic [31:0] base_c [2] = '{32'h0000_0000, 32'h0000_1000};
    int unsigned depth_c[2] = '{256, 16};
    int          lat_c  [2] = '{1, 4};

    always #5 hclk = ~hclk;

    assign rv0     = req_valid && (sel == 0);
    assign rv3     = req_valid && (sel == 1);
    assign din_m   = (sel == 1) ? din3   : din0;
    assign ready_m = (sel == 1) ? ready3 : ready0;
    assign err_m   = (sel == 1) ? err3   : err0;

    ahb_slave_mem #(.DEPTH(256), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(0)) dut0 (
        .hclk(hclk), .hreset(hreset), .req_valid(rv0), .addr_out(addr_out), .dout(dout),
        .hwrite_out(hwrite_out), .hsize_out(hsize_out), .din(din0), .ready(ready0), .err(err0)
    );

    ahb_slave_mem #(.DEPTH(16), .BASE_ADDR(32'h0000_1000), .WAIT_STATES(3)) dut3 (
        .hclk(hclk), .hreset(hreset), .req_valid(rv3), .addr_out(addr_out), .dout(dout),
        .hwrite_out(hwrite_out), .hsize_out(hsize_out), .din(din3), .ready(ready3), .err(err3)
    );

    // Reference model: decodes the request, updates its own memory copy, returns the expected response.
    task automatic model(input req_t r, output exp_t e);
        logic [31:0] off;
        logic        bad;
        int          idx, lo, hi;
        off = r.addr - base_c[sel];
        bad = (off >= 32'(depth_c[sel] * 4)) || (r.size > 3'd2);
`ifdef AHB_SLV_MEM_ALIGN_CHK_EN
        if (r.size == 3'd1 && r.addr[0]) bad = 1'b1;
        if (r.size == 3'd2 && r.addr[1:0] != 2'b00) bad = 1'b1;
`endif
        e.err  = bad;
        e.chk  = !r.write;
        e.data = 32'h0;
        if (!bad) begin
            idx = int'(off >> 2);
            if (r.write) begin
                if (r.size == 3'd0) begin
                    lo = int'(r.addr[1:0]);
                    hi = lo;
                end else if (r.size == 3'd1) begin
                    lo = r.addr[1] ? 2 : 0;
                    hi = lo + 1;
                end else begin
                    lo = 0;
                    hi = 3;
                end
                for (int b = lo; b <= hi; b++) mdl[sel][idx][8*b +: 8] = r.data[8*b +: 8];
            end else begin
                e.data = mdl[sel][idx];
            end
        end
    endtask

    task automatic push_req(input logic [31:0] a, input logic [31:0] d, input logic w, input logic [2:0] s);
        req_t r;
        r.addr = a; r.data = d; r.write = w; r.size = s;
        req_q.push_back(r);
    endtask

    task automatic apply(input req_t r);
        exp_t e;
        addr_out = r.addr; dout = r.data; hwrite_out = r.write; hsize_out = r.size;
        req_valid = 1'b1;
        model(r, e);
        exp_q.push_back(e);
    endtask

    // Issues every queued request, switching to the next one in the cycle ready is seen.
    task automatic run_queue(input string tag);
        int   since, budget;
        exp_t e;
        since = 0;
        budget = 0;
        @(negedge hclk);
        if (req_q.size() == 0) return;
        apply(req_q.pop_front());
        while (exp_q.size() > 0 && budget < 200) begin
            @(negedge hclk);
            since++;
            budget++;
            if (ready_m) begin
                e = exp_q.pop_front();
                checks++;
                if (since != lat_c[sel]) begin
                    errors++;
                    $display("[TB] FAIL %s latency: got %0d cycles, expected %0d", tag, since, lat_c[sel]);
                end
                checks++;
                if (err_m !== e.err) begin
                    errors++;
                    $display("[TB] FAIL %s err: got %b, expected %b", tag, err_m, e.err);
                end
                if (e.chk || e.err) begin
                    checks++;
                    if (din_m !== e.data) begin
                        errors++;
                        $display("[TB] FAIL %s din: got %h, expected %h", tag, din_m, e.data);
                    end
                end
                since = 0;
                if (req_q.size() > 0) apply(req_q.pop_front());
                else req_valid = 1'b0;
            end else begin
                checks++;
                if (err_m !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL %s err_without_ready: got %b, expected 0", tag, err_m);
                end
            end
        end
        if (exp_q.size() > 0) begin
            errors++;
            $display("[TB] FAIL %s timeout: got %0d responses outstanding, expected 0", tag, exp_q.size());
            exp_q.delete();
            req_q.delete();
        end
        req_valid = 1'b0;
    endtask

    task automatic test_reset;
        hreset = 1'b1;
        repeat (3) @(posedge hclk);
        @(negedge hclk);
        checks++;
        if ({din0, ready0, err0} !== 34'h0) begin
            errors++;
            $display("[TB] FAIL reset_dut0: got din=%h ready=%b err=%b, expected all 0", din0, ready0, err0);
        end
        checks++;
        if ({din3, ready3, err3} !== 34'h0) begin
            errors++;
            $display("[TB] FAIL reset_dut3: got din=%h ready=%b err=%b, expected all 0", din3, ready3, err3);
        end
        hreset = 1'b0;
    endtask

    task automatic test_word_rw;
        sel = 0;
        push_req(32'h10, 32'hDEAD_BEEF, 1'b1, 3'd2);
        push_req(32'h10, 32'h0, 1'b0, 3'd2);
        run_queue("word_rw");
    endtask

    task automatic test_byte_half;
        sel = 0;
        push_req(32'h10, 32'h1122_3344, 1'b1, 3'd2);
        push_req(32'h12, 32'h00AA_0000, 1'b1, 3'd0);
        push_req(32'h10, 32'h0, 1'b0, 3'd2);
        push_req(32'h10, 32'h0000_5566, 1'b1, 3'd1);
        push_req(32'h10, 32'h0, 1'b0, 3'd2);
        push_req(32'h17, 32'h7700_0000, 1'b1, 3'd0);
        push_req(32'h16, 32'h8899_0000, 1'b1, 3'd1);
        push_req(32'h14, 32'h0, 1'b0, 3'd2);
        run_queue("byte_half");
    endtask

    task automatic test_back_to_back;
        sel = 0;
        push_req(32'h0, 32'h0101_0101, 1'b1, 3'd2);
        push_req(32'h4, 32'h0202_0202, 1'b1, 3'd2);
        push_req(32'h8, 32'h0303_0303, 1'b1, 3'd2);
        push_req(32'h0, 32'h0, 1'b0, 3'd2);
        push_req(32'h4, 32'h0, 1'b0, 3'd2);
        push_req(32'h8, 32'h0, 1'b0, 3'd2);
        run_queue("back_to_back");
    endtask

    task automatic test_errors;
        sel = 0;
        push_req(32'h400, 32'hFFFF_FFFF, 1'b1, 3'd2);
        push_req(32'h10, 32'h0, 1'b0, 3'd3);
        push_req(32'h10, 32'h0, 1'b0, 3'd2);
        push_req(32'h0, 32'h0, 1'b0, 3'd2);
        push_req(32'h0, 32'h9999_9999, 1'b1, 3'd7);
        push_req(32'h0, 32'h0, 1'b0, 3'd2);
        run_queue("errors");
    endtask

    task automatic test_align;
        sel = 0;
        push_req(32'h2, 32'hCAFE_F00D, 1'b1, 3'd2);
        push_req(32'h0, 32'h0, 1'b0, 3'd2);
        run_queue("align");
    endtask

    task automatic test_wait_states;
        sel = 1;
        push_req(32'h1004, 32'h0BAD_C0DE, 1'b1, 3'd2);
        push_req(32'h103C, 32'h5A5A_5A5A, 1'b1, 3'd2);
        push_req(32'h103C, 32'h0, 1'b0, 3'd2);
        push_req(32'h1040, 32'h0, 1'b0, 3'd2);
        push_req(32'h0FFC, 32'h0, 1'b0, 3'd2);
        push_req(32'h1008, 32'hA5A5_0001, 1'b1, 3'd2);
        run_queue("wait_states");
    endtask

    task automatic test_wait_ignore;
        req_t r;
        exp_t e;
        int   nready;
        sel = 1;
        nready = 0;
        @(negedge hclk);
        r.addr = 32'h1000; r.data = 32'h1234_5678; r.write = 1'b1; r.size = 3'd2;
        apply(r);
        for (int c = 1; c <= 10; c++) begin
            @(negedge hclk);
            if (ready_m) begin
                nready++;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    checks++;
                    if (c != 4 || err_m !== e.err) begin
                        errors++;
                        $display("[TB] FAIL wait_ignore resp: got cycle %0d err=%b, expected cycle 4 err=%b", c, err_m, e.err);
                    end
                end
                req_valid = 1'b0;
            end
            if (c == 2) begin
                addr_out = 32'h1004; dout = 32'hFFFF_FFFF; req_valid = 1'b1;
            end else if (c == 3) begin
                req_valid = 1'b0;
            end
        end
        checks++;
        if (nready != 1) begin
            errors++;
            $display("[TB] FAIL wait_ignore count: got %0d responses, expected 1", nready);
        end
        exp_q.delete();
        req_valid = 1'b0;
        push_req(32'h1000, 32'h0, 1'b0, 3'd2);
        push_req(32'h1004, 32'h0, 1'b0, 3'd2);
        run_queue("wait_ignore_rd");
    endtask

    task automatic test_reset_mid;
        int nready;
        sel = 1;
        nready = 0;
        @(negedge hclk);
        addr_out = 32'h1008; dout = 32'h0000_FFFF; hwrite_out = 1'b1; hsize_out = 3'd2;
        req_valid = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge hclk);
            if (ready_m) nready++;
            if (c == 2) begin
                hreset = 1'b1;
                req_valid = 1'b0;
            end else if (c == 3) begin
                hreset = 1'b0;
            end
        end
        checks++;
        if (nready != 0) begin
            errors++;
            $display("[TB] FAIL reset_mid ready: got %0d responses, expected 0", nready);
        end
        checks++;
        if (din3 !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_mid din: got %h, expected 00000000", din3);
        end
        push_req(32'h1008, 32'h0, 1'b0, 3'd2);
        run_queue("reset_mid_rd");
    endtask

    initial begin
        hreset = 1'b1;
        req_valid = 1'b0;
        addr_out = 32'h0;
        dout = 32'h0;
        hwrite_out = 1'b0;
        hsize_out = 3'd0;
        test_reset();
        test_word_rw();
        test_byte_half();
        test_back_to_back();
        test_errors();
        test_align();
        test_wait_states();
        test_wait_ignore();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
